mod_enc_shiftrows_stream: RTL



---
 rtl/mod_enc_shiftrows_stream.sv | 111 +++++++++++
 1 files changed

// File: rtl/mod_enc_shiftrows_stream.sv
// Row-serial ShiftRows/InvShiftRows stage for Rijndael NB = 4/6/8.
// Ports: clk, resetn, flush; in_valid/in_ready/in_row/in_first/in_dec;
// out_valid/out_ready/out_row/out_idx/out_last; err_sync.
// Optional: define SHR_ROWCHK_EN to enable in_first resync and err_sync.
module mod_enc_shiftrows_stream #(
  parameter int NB   = 4,
  parameter int ROWS = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NB*8-1:0] in_row,
  input  logic          in_first,
  input  logic          in_dec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NB*8-1:0] out_row,
  output logic [1:0]    out_idx,
  output logic          out_last,
  output logic          err_sync
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("NB must be 4, 6 or 8");
  end
  if (ROWS != 4) begin : g_bad_rows
    $error("ROWS must be 4");
  end

  logic [1:0]      cnt;
  logic            mode;
  logic            accept;
  logic            resync;
  logic [1:0]      eff_row;
  logic            eff_mode;
  logic [NB*8-1:0] rot;

  function automatic int row_off(input logic [1:0] r);
    int o;
    o = int'(r);
    if (NB == 8) begin
      unique case (r)
        2'd2:    o = 3;
        2'd3:    o = 4;
        default: o = int'(r);
      endcase
    end
    return o;
  endfunction

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef SHR_ROWCHK_EN
  // A first-row marker mid-block restarts the block at row 0.
  assign resync  = in_first & (cnt != 2'd0);
`else
  logic unused_first;
  assign unused_first = in_first;
  assign resync  = 1'b0;
`endif

  assign eff_row  = resync ? 2'd0 : cnt;
  assign eff_mode = (eff_row == 2'd0) ? in_dec : mode;

  always_comb begin
    int off;
    int src;
    rot = '0;
    off = row_off(eff_row);
    for (int j = 0; j < NB; j++) begin
      if (eff_mode)
        src = (j - off + NB) % NB;
      else
        src = (j + off) % NB;
      rot[8*j +: 8] = in_row[8*src +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= 2'd0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      err_sync  <= 1'b0;
    end else if (flush) begin
      cnt       <= 2'd0;
      out_valid <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      err_sync <= 1'b0;
      if (accept) begin
        out_row   <= rot;
        out_idx   <= eff_row;
        out_last  <= (eff_row == 2'd3);
        out_valid <= 1'b1;
        cnt       <= eff_row + 2'd1;
        mode      <= eff_mode;
        err_sync  <= resync;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
